// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS main control FSM with mem_ready stretching
module mips_multicycle_ctrl (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       run,
    input  logic [5:0] opcode,
    input  logic       zero,
    input  logic       mem_ready,
    output logic [1:0] OpALU,
    output logic       ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] PCSource,
    output logic       PCWrite,
    output logic       PCWriteCond,
    output logic       IorD,
    output logic       MemRead,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegDst,
    output logic       MemtoReg,
    output logic       RegWrite,
    output logic       illegal_op,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_FETCH  = 4'd1,
        S_DECODE = 4'd2,
        S_MEMADR = 4'd3,
        S_MEMRD  = 4'd4,
        S_MEMWB  = 4'd5,
        S_MEMWR  = 4'd6,
        S_EXEC   = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9,
        S_JUMP   = 4'd10,
        S_ADDIEX = 4'd11,
        S_ADDIWB = 4'd12
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    state_t state_q;
    state_t state_d;
    logic   op_legal;

    // zero gates PCWriteCond in the datapath; the FSM itself never looks at it
    logic unused_zero;
    assign unused_zero = zero;

    assign op_legal = (opcode == OP_RTYPE) || (opcode == OP_LW) || (opcode == OP_SW) ||
                      (opcode == OP_BEQ) || (opcode == OP_J) || (opcode == OP_ADDI);

    assign state = state_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            illegal_op <= 1'b0;
        end else begin
            state_q    <= state_d;
            illegal_op <= (state_q == S_DECODE) && !op_legal;
        end
    end

    always_comb begin
        state_d     = state_q;
        OpALU       = 2'b00;
        ALUSrcA     = 1'b0;
        ALUSrcB     = 2'b00;
        PCSource    = 2'b00;
        PCWrite     = 1'b0;
        PCWriteCond = 1'b0;
        IorD        = 1'b0;
        MemRead     = 1'b0;
        MemWrite    = 1'b0;
        IRWrite     = 1'b0;
        RegDst      = 1'b0;
        MemtoReg    = 1'b0;
        RegWrite    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (run) state_d = S_FETCH;
            end
            S_FETCH: begin
                MemRead = 1'b1;
                ALUSrcB = 2'b01;
                IRWrite = mem_ready;
                PCWrite = mem_ready;
                if (mem_ready) state_d = S_DECODE;
            end
            S_DECODE: begin
                ALUSrcB = 2'b11;
                case (opcode)
                    OP_RTYPE:      state_d = S_EXEC;
                    OP_LW, OP_SW:  state_d = S_MEMADR;
                    OP_BEQ:        state_d = S_BRANCH;
                    OP_J:          state_d = S_JUMP;
                    OP_ADDI:       state_d = S_ADDIEX;
                    default:       state_d = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = (opcode == OP_LW) ? S_MEMRD : S_MEMWR;
            end
            S_MEMRD: begin
                MemRead = 1'b1;
                IorD    = 1'b1;
                if (mem_ready) state_d = S_MEMWB;
            end
            S_MEMWB: begin
                RegWrite = 1'b1;
                MemtoReg = 1'b1;
                state_d  = S_FETCH;
            end
            S_MEMWR: begin
                MemWrite = 1'b1;
                IorD     = 1'b1;
                if (mem_ready) state_d = S_FETCH;
            end
            S_EXEC: begin
                ALUSrcA = 1'b1;
                OpALU   = 2'b10;
                state_d = S_ALUWB;
            end
            S_ALUWB: begin
                RegWrite = 1'b1;
                RegDst   = 1'b1;
                state_d  = S_FETCH;
            end
            S_BRANCH: begin
                ALUSrcA     = 1'b1;
                OpALU       = 2'b01;
                PCWriteCond = 1'b1;
                PCSource    = 2'b01;
                state_d     = S_FETCH;
            end
            S_JUMP: begin
                PCWrite  = 1'b1;
                PCSource = 2'b10;
                state_d  = S_FETCH;
            end
            S_ADDIEX: begin
                ALUSrcA = 1'b1;
                ALUSrcB = 2'b10;
                state_d = S_ADDIWB;
            end
            S_ADDIWB: begin
                RegWrite = 1'b1;
                state_d  = S_FETCH;
            end
            default: state_d = S_IDLE;
        endcase
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - randomized instruction-plan bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset_n;
    logic       run;
    logic [5:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic [1:0] OpALU;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic [1:0] PCSource;
    logic       PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite;
    logic       RegDst, MemtoReg, RegWrite, illegal_op;
    logic [3:0] state;

    mips_multicycle_ctrl dut (
        .clk(clk), .reset_n(reset_n), .run(run), .opcode(opcode), .zero(zero),
        .mem_ready(mem_ready), .OpALU(OpALU), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB),
        .PCSource(PCSource), .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD),
        .MemRead(MemRead), .MemWrite(MemWrite), .IRWrite(IRWrite), .RegDst(RegDst),
        .MemtoReg(MemtoReg), .RegWrite(RegWrite), .illegal_op(illegal_op), .state(state)
    );

    always #5 clk = ~clk;

    typedef struct {
        int         st;
        logic       mr;
        logic [5:0] op;
        logic       ill;
        logic       pin;
    } step_t;

    step_t plan[$];
    logic  pend_ill = 1'b0;
    int    n_checks = 0;
    int    n_errors = 0;
    logic  exp_valid = 1'b0;
    int    exp_state = 0;
    logic  exp_ill = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Control word required in each state code, read straight off the state table
    function automatic logic [15:0] exp_ctrl(input int s, input logic mr);
        logic [1:0] op, srcb, pcs;
        logic srca, pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw;
        op = 0; srcb = 0; pcs = 0;
        srca = 0; pcw = 0; pcwc = 0; iord = 0; mrd = 0; mwr = 0; irw = 0; rdst = 0; m2r = 0; rw = 0;
        case (s)
            1:  begin mrd = 1; srcb = 2'b01; irw = mr; pcw = mr; end
            2:  srcb = 2'b11;
            3:  begin srca = 1; srcb = 2'b10; end
            4:  begin mrd = 1; iord = 1; end
            5:  begin rw = 1; m2r = 1; end
            6:  begin mwr = 1; iord = 1; end
            7:  begin srca = 1; op = 2'b10; end
            8:  begin rw = 1; rdst = 1; end
            9:  begin srca = 1; op = 2'b01; pcwc = 1; pcs = 2'b01; end
            10: begin pcw = 1; pcs = 2'b10; end
            11: begin srca = 1; srcb = 2'b10; end
            12: rw = 1;
            default: ;
        endcase
        return {op, srca, srcb, pcs, pcw, pcwc, iord, mrd, mwr, irw, rdst, m2r, rw};
    endfunction

    function automatic step_t mk(input int st, input logic mr, input logic [5:0] op, input logic pin);
        step_t s;
        s.st = st; s.mr = mr; s.op = op; s.ill = 1'b0; s.pin = pin;
        return s;
    endfunction

    // Expand one instruction into its per-cycle expected states and mem_ready drive
    task automatic add_instr(input logic [5:0] op, input int fst, input int mst, input logic pin);
        step_t s;
        int nf;
        nf = pend_ill ? 0 : fst;
        for (int i = 0; i <= nf; i++) begin
            s = mk(1, (i == nf), op, pin);
            if (i == 0) begin
                s.ill = pend_ill;
                pend_ill = 1'b0;
            end
            plan.push_back(s);
        end
        plan.push_back(mk(2, 1'($urandom_range(0, 1)), op, pin));
        case (op)
            6'b000000: begin
                plan.push_back(mk(7, 1'($urandom_range(0, 1)), op, pin));
                plan.push_back(mk(8, 1'($urandom_range(0, 1)), op, pin));
            end
            6'b100011, 6'b101011: begin
                plan.push_back(mk(3, 1'($urandom_range(0, 1)), op, pin));
                for (int i = 0; i <= mst; i++)
                    plan.push_back(mk((op == 6'b100011) ? 4 : 6, (i == mst), op, pin));
                if (op == 6'b100011) plan.push_back(mk(5, 1'($urandom_range(0, 1)), op, pin));
            end
            6'b000100: plan.push_back(mk(9, 1'($urandom_range(0, 1)), op, pin));
            6'b000010: plan.push_back(mk(10, 1'($urandom_range(0, 1)), op, pin));
            6'b001000: begin
                plan.push_back(mk(11, 1'($urandom_range(0, 1)), op, pin));
                plan.push_back(mk(12, 1'($urandom_range(0, 1)), op, pin));
            end
            default: pend_ill = 1'b1;
        endcase
    endtask

    task automatic pin_check(input step_t s);
        case (s.st)
            1: begin
                chk("fetch_memread", MemRead, 1);
                if (s.mr) chk("fetch_irwrite_ready", IRWrite, 1);
                else      chk("fetch_irwrite_stall", IRWrite, 0);
                if (s.ill) chk("illegal_pulse", illegal_op, 1);
            end
            4:  chk("memrd_hold", {state, MemRead, IorD}, {4'd4, 2'b11});
            5:  chk("memwb_ctrl", {MemtoReg, RegWrite}, 2'b11);
            6:  chk("memwr_ctrl", {MemWrite, IorD}, 2'b11);
            7:  chk("exec_opalu", OpALU, 2'b10);
            8:  chk("aluwb_ctrl", {RegWrite, RegDst}, 2'b11);
            9:  chk("branch_ctrl", {OpALU, PCWriteCond, PCSource}, 5'b01101);
            10: chk("jump_ctrl", {PCWrite, PCSource}, 3'b110);
            default: ;
        endcase
    endtask

    always @(negedge clk) begin
        if (exp_valid) begin
            chk("state", state, exp_state);
            chk("ctrl", {OpALU, ALUSrcA, ALUSrcB, PCSource, PCWrite, PCWriteCond, IorD, MemRead,
                         MemWrite, IRWrite, RegDst, MemtoReg, RegWrite},
                exp_ctrl(exp_state, mem_ready));
            chk("illegal_op", illegal_op, exp_ill);
        end
    end

    localparam logic [5:0] LEGAL [6] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010, 6'b001000};
    localparam logic [5:0] BAD   [3] = '{6'b111111, 6'b000001, 6'b100000};

    initial begin
        int lw_start;
        reset_n = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = 6'b0; zero = 1'b0;
        exp_state = 0; exp_ill = 1'b0; exp_valid = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        @(negedge clk);
        run = 1'b1;

        add_instr(6'b000000, 0, 0, 1'b1);
        lw_start = plan.size();
        add_instr(6'b100011, 0, 2, 1'b1);
        chk("lw_latency", plan.size() - lw_start, 7);
        add_instr(6'b101011, 1, 0, 1'b1);
        add_instr(6'b000100, 0, 0, 1'b1);
        add_instr(6'b000010, 0, 0, 1'b1);
        add_instr(6'b001000, 0, 0, 1'b1);
        for (int i = 0; i < 80; i++) begin
            if ($urandom_range(0, 7) == 0)
                add_instr(BAD[$urandom_range(0, 2)], $urandom_range(0, 2), 0, 1'b0);
            else
                add_instr(LEGAL[$urandom_range(0, 5)], $urandom_range(0, 2), $urandom_range(0, 2), 1'b0);
        end
        add_instr(6'b111111, 0, 0, 1'b1);
        add_instr(6'b000000, 0, 0, 1'b1);
        void'(plan.pop_back());

        foreach (plan[k]) begin
            @(posedge clk);
            #1;
            mem_ready = plan[k].mr;
            opcode    = plan[k].op;
            zero      = 1'($urandom_range(0, 1));
            exp_state = plan[k].st;
            exp_ill   = plan[k].ill;
            #1;
            if (plan[k].pin) pin_check(plan[k]);
        end

        #1;
        exp_state = 0;
        exp_ill   = 1'b0;
        reset_n   = 1'b0;
        #1;
        chk("async_reset_state", state, 0);
        chk("async_reset_strobes", {RegWrite, MemWrite, PCWrite, IRWrite, illegal_op}, 0);
        repeat (2) @(negedge clk);
        #1;
        exp_valid = 1'b0;
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
# mips_multicycle_ctrl

Multi-cycle main control FSM for the MIPS core. It sequences one instruction through fetch, decode, execute, memory and writeback, and drives the `OpALU` code consumed by the ALU-control/ALU pair. It also drives the mux selects and write enables for the PC, IR, register file and memory. Memory accesses are stretched by a `mem_ready` handshake.

## Interface
- No parameters. The opcode encodings below are fixed.
- `clk` in 1: rising-edge clock.
- `reset_n` in 1: asynchronous, active-low reset.
- `run` in 1: while high, leaves IDLE and executes instructions. Sampled only in IDLE.
- `opcode` in [0:5]: IR[31:26]. Sampled in DECODE.
- `zero` in 1: ALU zero flag. Consumed only via `PCWriteCond`.
- `mem_ready` in 1: memory has completed the current read or write this cycle.
- `OpALU` out [0:1]: 00 = add, 01 = sub, 10 = use funct.
- `ALUSrcA` out 1: 0 = PC, 1 = register A.
- `ALUSrcB` out [0:1]: 00 = B, 01 = constant 4, 10 = sign-extended imm, 11 = sign-extended imm << 2.
- `PCSource` out [0:1]: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `PCWrite`, `PCWriteCond`, `IorD`, `MemRead`, `MemWrite`, `IRWrite`, `RegDst`, `MemtoReg`, `RegWrite` out 1 each: standard multi-cycle controls.
- `illegal_op` out 1: one-cycle pulse on an unsupported opcode.
- `state` out [0:3]: current state code, for debug.

## Operation
State codes:
- 0 IDLE
- 1 FETCH
- 2 DECODE
- 3 MEMADR
- 4 MEMRD
- 5 MEMWB
- 6 MEMWR
- 7 EXEC
- 8 ALUWB
- 9 BRANCH
- 10 JUMP
- 11 ADDIEX
- 12 ADDIWB
- 13–15 unused. An unused code goes to IDLE on the next edge.

Opcodes decoded in DECODE:
- 000000 R-type → EXEC
- 100011 lw → MEMADR
- 101011 sw → MEMADR
- 000100 beq → BRANCH
- 000010 j → JUMP
- 001000 addi → ADDIEX
- Any other opcode → FETCH, with `illegal_op` = 1 for the cycle spent in that next FETCH.

Transitions and outputs per state (any output not listed is 0):
- IDLE: all outputs 0. Goes to FETCH when `run` = 1.
- FETCH:
  - `MemRead` = 1, `IorD` = 0, `ALUSrcA` = 0, `ALUSrcB` = 01, `OpALU` = 00, `PCSource` = 00.
  - `IRWrite` = `PCWrite` = `mem_ready`.
  - Stays in FETCH while `mem_ready` = 0; goes to DECODE when it is 1.
- DECODE: `ALUSrcA` = 0, `ALUSrcB` = 11, `OpALU` = 00. Computes the branch target.
- MEMADR: `ALUSrcA` = 1, `ALUSrcB` = 10, `OpALU` = 00. Goes to MEMRD for lw, MEMWR for sw (opcode held stable by IR).
- MEMRD: `MemRead` = 1, `IorD` = 1. Waits on `mem_ready`, then goes to MEMWB.
- MEMWB: `RegWrite` = 1, `MemtoReg` = 1, `RegDst` = 0. Goes to FETCH.
- MEMWR: `MemWrite` = 1, `IorD` = 1. Waits on `mem_ready`, then goes to FETCH.
- EXEC: `ALUSrcA` = 1, `ALUSrcB` = 00, `OpALU` = 10. Goes to ALUWB.
- ALUWB: `RegWrite` = 1, `RegDst` = 1, `MemtoReg` = 0. Goes to FETCH.
- BRANCH: `ALUSrcA` = 1, `ALUSrcB` = 00, `OpALU` = 01, `PCWriteCond` = 1, `PCSource` = 01. Goes to FETCH.
- JUMP: `PCWrite` = 1, `PCSource` = 10. Goes to FETCH.
- ADDIEX: `ALUSrcA` = 1, `ALUSrcB` = 10, `OpALU` = 00. Goes to ADDIWB.
- ADDIWB: `RegWrite` = 1, `RegDst` = 0, `MemtoReg` = 0. Goes to FETCH.

`run` low outside IDLE has no effect. The current instruction completes and the FSM keeps fetching; to stop, assert reset.

## Timing
- Reset: `reset_n` = 0 immediately forces `state` = IDLE and `illegal_op` = 0, with no clock required. All outputs read 0 while in reset.
- Reset mid-instruction: the instruction is abandoned. No write strobe may be asserted in the cycle after reset assertion.
- Outputs are Moore, decoded from the state register. The exceptions are `IRWrite`/`PCWrite` in FETCH, which are gated by `mem_ready`.
- `illegal_op` is registered.
- Latency with `mem_ready` tied to 1:
  - R-type: 4 cycles
  - lw: 5 cycles
  - sw: 4 cycles
  - beq: 3 cycles
  - j: 3 cycles
  - addi: 4 cycles
- Each cycle with `mem_ready` = 0 in FETCH, MEMRD or MEMWR adds one cycle.
- `mem_ready` is ignored in all other states.

## Test plan
- Reset: hold `reset_n` = 0 for 3 cycles, then release with `run` = 0.
  - Required: `state` = 0 and all outputs 0 throughout.
  - Raise `run`: next edge gives `state` = 1 and `MemRead` = 1.
- R-type with `mem_ready` = 1 and `opcode` = 000000:
  - Required sequence: FETCH(1) → DECODE(2) → EXEC(7) → ALUWB(8) → FETCH.
  - `OpALU` = 10 in EXEC; `RegWrite` = 1 and `RegDst` = 1 in ALUWB.
- lw with `mem_ready` low for 2 cycles in MEMRD:
  - Required: the FSM stays in state 4 for 3 cycles, then MEMWB with `MemtoReg` = 1 and `RegWrite` = 1.
  - Total latency 7 cycles.
- sw with a FETCH stall of 1 cycle:
  - Required: `IRWrite` = 0 on the stalled cycle and 1 on the ready cycle.
  - MEMWR has `MemWrite` = 1 and `IorD` = 1, then FETCH.
- beq (000100) and j (000010):
  - beq: BRANCH has `OpALU` = 01, `PCWriteCond` = 1, `PCSource` = 01.
  - j: JUMP has `PCWrite` = 1, `PCSource` = 10.
  - Both return to FETCH after 3 cycles.
- Illegal opcode 111111, then reset asserted mid-EXEC of a following R-type:
  - Required: `illegal_op` = 1 for exactly one cycle, in the FETCH after DECODE.
  - After the async reset, `state` = 0 before the next clock edge, with `RegWrite` never asserted.
